// File: rtl/mips_defs.sv
// -----------------------------------------------------------------------------
// mips_defs
//   Shared definitions for the multicycle MIPS control unit and its datapath:
//   opcode/funct constants, FSM state encoding, ALU operation codes, the
//   alu_src_b and pc_src mux codes, and the packed control word the FSM emits.
// -----------------------------------------------------------------------------
package mips_defs;

    // Opcodes, IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct field, IR[5:0]
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // FSM encoding is visible on the debug port, so the values are fixed.
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMRD    = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWR    = 4'd5,
        ST_RTYPE_EX = 4'd6,
        ST_RTYPE_WB = 4'd7,
        ST_BEQ_EX   = 4'd8,
        ST_ADDI_EX  = 4'd9,
        ST_ADDI_WB  = 4'd10,
        ST_J_EX     = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        SRCB_REGB    = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_src_t;

    // Everything the FSM drives into the datapath, in one word.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        pc_src_t    pc_src;
        alu_ctrl_t  alu_ctrl;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
//   Combinational R-type funct -> ALU operation decode.
//   Ports:
//     funct    in  6  IR[5:0]
//     alu_ctrl out 3  ALU operation; 000 when funct is unsupported
//     valid    out 1  funct is one of add/sub/and/or/slt
// -----------------------------------------------------------------------------
module alu_decoder
    import mips_defs::*;
(
    input  logic [5:0] funct,
    output alu_ctrl_t  alu_ctrl,
    output logic       valid
);

    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned; otherwise synthesis infers a latch.
    always_comb begin
        alu_ctrl = ALU_AND;
        valid    = 1'b1;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            default: valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Moore control FSM for the multicycle MIPS core. Sequences the shared memory
//   port, ALU and register file through FETCH/DECODE/EXECUTE/MEM/WRITEBACK for
//   add/sub/and/or/slt, lw, sw, beq, addi and j, with mem_ready wait states.
//   Ports:
//     clk, reset          clock; synchronous active-low reset
//     opcode, funct       instruction register fields
//     zero                ALU zero flag (consumed by the datapath through
//                         pc_write_cond; not needed by the FSM itself)
//     mem_ready           memory completes the current access this cycle
//     pc_write .. pc_src  datapath enables and mux selects
//     alu_ctrl            ALU operation
//     state               current FSM state, for debug
//     illegal             one-cycle pulse on unsupported opcode/funct
//     instr_retired       completed-instruction count, wraps at 2^CNT_W
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl
    import mips_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [2:0]       alu_ctrl,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_retired
);

    state_t    state_q;
    state_t    state_d;
    ctrl_t     ctl;
    alu_ctrl_t rtype_alu;
    logic      funct_ok;
    logic      retire;
    logic      bad_opcode;
    logic      bad_funct;

    // Branch resolution happens in the datapath (zero AND pc_write_cond).
    logic      unused_zero;
    assign unused_zero = zero;

    alu_decoder u_alu_decoder (
        .funct    (funct),
        .alu_ctrl (rtype_alu),
        .valid    (funct_ok)
    );

    // -------------------------------------------------------------------------
    // State and retired-instruction counter
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_FETCH;
            instr_retired <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instr_retired <= instr_retired + CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        bad_opcode = 1'b0;
        bad_funct  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = ST_RTYPE_EX;
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_BEQ:       state_d = ST_BEQ_EX;
                    OP_ADDI:      state_d = ST_ADDI_EX;
                    OP_J:         state_d = ST_J_EX;
                    default: begin
                        state_d    = ST_FETCH;
                        bad_opcode = 1'b1;
                    end
                endcase
            end
            ST_MEMADR: begin
                // Only lw and sw reach MEMADR, so anything but sw is a load.
                state_d = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                if (mem_ready) state_d = ST_MEMWB;
            end
            ST_MEMWR: begin
                if (mem_ready) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_RTYPE_EX: begin
                if (funct_ok) begin
                    state_d = ST_RTYPE_WB;
                end else begin
                    state_d   = ST_FETCH;
                    bad_funct = 1'b1;
                end
            end
            ST_ADDI_EX: begin
                state_d = ST_ADDI_WB;
            end
            ST_MEMWB, ST_RTYPE_WB, ST_BEQ_EX, ST_ADDI_WB, ST_J_EX: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            default: begin
                // Unused encodings recover to FETCH.
                state_d = ST_FETCH;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        ctl = '0;
        case (state_q)
            ST_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_ctrl  = ALU_ADD;
                // IR and PC+4 are only captured when the fetch completes.
                ctl.ir_write  = mem_ready;
                ctl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                // Precompute the branch target into ALUOut.
                ctl.alu_src_b = SRCB_IMM_SH2;
                ctl.alu_ctrl  = ALU_ADD;
            end
            ST_MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_ctrl  = ALU_ADD;
            end
            ST_MEMRD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
            end
            ST_MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
            end
            ST_RTYPE_EX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_REGB;
                ctl.alu_ctrl  = rtype_alu;
            end
            ST_RTYPE_WB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
            end
            ST_BEQ_EX: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_src_b     = SRCB_REGB;
                ctl.alu_ctrl      = ALU_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_src        = PCSRC_ALUOUT;
            end
            ST_ADDI_EX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_ctrl  = ALU_ADD;
            end
            ST_ADDI_WB: begin
                ctl.reg_write = 1'b1;
            end
            ST_J_EX: begin
                ctl.pc_write = 1'b1;
                ctl.pc_src   = PCSRC_JUMP;
            end
            default: ;
        endcase

        // While reset is held no architectural state may change, even though
        // the state register still shows the state being aborted.
        if (!reset) begin
            ctl.pc_write      = 1'b0;
            ctl.pc_write_cond = 1'b0;
            ctl.ir_write      = 1'b0;
            ctl.mem_write     = 1'b0;
            ctl.reg_write     = 1'b0;
            ctl.mem_read      = 1'b0;
        end
    end

    assign pc_write      = ctl.pc_write;
    assign pc_write_cond = ctl.pc_write_cond;
    assign iord          = ctl.iord;
    assign mem_read      = ctl.mem_read;
    assign mem_write     = ctl.mem_write;
    assign ir_write      = ctl.ir_write;
    assign reg_dst       = ctl.reg_dst;
    assign mem_to_reg    = ctl.mem_to_reg;
    assign reg_write     = ctl.reg_write;
    assign alu_src_a     = ctl.alu_src_a;
    assign alu_src_b     = ctl.alu_src_b;
    assign pc_src        = ctl.pc_src;
    assign alu_ctrl      = ctl.alu_ctrl;
    assign state         = state_q;
    assign illegal       = reset & (bad_opcode | bad_funct);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//   Directed stimulus for the multicycle control FSM. The driver pushes the
//   expected state, control word, illegal flag and retired count for every
//   cycle into a scoreboard queue; a monitor on the falling edge pops and
//   compares. The counter is built 4 bits wide so the wrap is reachable.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    localparam int CNT_W = 4;

    // State numbers as they appear on the debug port
    localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE   = 4'd1,  S_MEMADR   = 4'd2,
                           S_MEMRD = 4'd3,  S_MEMWB    = 4'd4,  S_MEMWR    = 4'd5,
                           S_RT_EX = 4'd6,  S_RT_WB    = 4'd7,  S_BEQ_EX   = 4'd8,
                           S_AD_EX = 4'd9,  S_AD_WB    = 4'd10, S_J_EX     = 4'd11;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                           BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010,
                           BAD_OP = 6'b111111;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_OR = 6'b100101,
                           F_SLT = 6'b101010, F_BAD = 6'b000000;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic             reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_src;
    logic [2:0]       alu_ctrl;
    logic [3:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] instr_retired;

    mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_src        (pc_src),
        .alu_ctrl      (alu_ctrl),
        .state         (state),
        .illegal       (illegal),
        .instr_retired (instr_retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]       st;
        logic [16:0]      ctl;
        logic             ill;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb_q[$];
    int               vectors     = 0;
    int               miscompares = 0;
    logic [CNT_W-1:0] exp_cnt;

    // Control word packing:
    // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
    //  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src, alu_ctrl}
    function automatic logic [16:0] spec_ctl(input logic [3:0] st, input logic rst,
                                             input logic mr, input logic [2:0] rt_alu);
        logic pcw = 0, pcwc = 0, io = 0, mrd = 0, mwr = 0, irw = 0;
        logic rdst = 0, m2r = 0, rw = 0, sa = 0;
        logic [1:0] srcb = 2'b00, ps = 2'b00;
        logic [2:0] alu = 3'b000;
        case (st)
            S_FETCH:  begin mrd = 1; srcb = 2'b01; alu = 3'b010; irw = mr; pcw = mr; end
            S_DECODE: begin srcb = 2'b11; alu = 3'b010; end
            S_MEMADR: begin sa = 1; srcb = 2'b10; alu = 3'b010; end
            S_MEMRD:  begin mrd = 1; io = 1; end
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_MEMWR:  begin mwr = 1; io = 1; end
            S_RT_EX:  begin sa = 1; alu = rt_alu; end
            S_RT_WB:  begin rw = 1; rdst = 1; end
            S_BEQ_EX: begin sa = 1; alu = 3'b110; pcwc = 1; ps = 2'b01; end
            S_AD_EX:  begin sa = 1; srcb = 2'b10; alu = 3'b010; end
            S_AD_WB:  begin rw = 1; end
            S_J_EX:   begin pcw = 1; ps = 2'b10; end
            default: ;
        endcase
        if (!rst) begin
            pcw = 0; pcwc = 0; irw = 0; mwr = 0; rw = 0; mrd = 0;
        end
        return {pcw, pcwc, io, mrd, mwr, irw, rdst, m2r, rw, sa, srcb, ps, alu};
    endfunction

    // One clock cycle: drive inputs just after the edge and queue what the
    // DUT must show for the rest of this cycle.
    task automatic cyc(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic mr, input logic z, input logic [3:0] es,
                       input logic eill, input logic [2:0] rt_alu);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        opcode    = op;
        funct     = fn;
        mem_ready = mr;
        zero      = z;
        e.st  = es;
        e.ctl = spec_ctl(es, rst, mr, rt_alu);
        e.ill = eill;
        e.cnt = exp_cnt;
        sb_q.push_back(e);
    endtask

    // FETCH with `waits` not-ready cycles, then DECODE.
    task automatic fetch_dec(input logic [5:0] op, input logic [5:0] fn,
                             input int waits, input logic ill_dec);
        for (int i = 0; i < waits; i++) cyc(1, op, fn, 0, 0, S_FETCH, 0, 3'b000);
        cyc(1, op, fn, 1, 0, S_FETCH, 0, 3'b000);
        cyc(1, op, fn, 0, 0, S_DECODE, ill_dec, 3'b000);
    endtask

    task automatic retire_one();
        exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic run_lw();
        fetch_dec(LW, 6'd0, 0, 0);
        cyc(1, LW, 6'd0, 0, 0, S_MEMADR, 0, 3'b000);
        cyc(1, LW, 6'd0, 1, 0, S_MEMRD,  0, 3'b000);
        cyc(1, LW, 6'd0, 0, 0, S_MEMWB,  0, 3'b000);
        retire_one();
    endtask

    task automatic run_rtype(input logic [5:0] fn, input logic [2:0] alu);
        fetch_dec(RT, fn, 0, 0);
        cyc(1, RT, fn, 1, 0, S_RT_EX, 0, alu);
        cyc(1, RT, fn, 0, 0, S_RT_WB, 0, 3'b000);
        retire_one();
    endtask

    task automatic run_addi();
        fetch_dec(ADDI, 6'd0, 0, 0);
        cyc(1, ADDI, 6'd0, 0, 0, S_AD_EX, 0, 3'b000);
        cyc(1, ADDI, 6'd0, 1, 0, S_AD_WB, 0, 3'b000);
        retire_one();
    endtask

    // Monitor: every queued vector is checked on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        logic [16:0] act_ctl;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            vectors++;
            act_ctl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                       reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src,
                       alu_ctrl};
            if (state !== e.st) begin
                miscompares++;
                $display("FAIL state vec %0d: got %0d, want %0d", vectors, state, e.st);
            end
            if (act_ctl !== e.ctl) begin
                miscompares++;
                $display("FAIL ctrl vec %0d (state %0d): got %05h, want %05h",
                         vectors, e.st, act_ctl, e.ctl);
            end
            if (illegal !== e.ill) begin
                miscompares++;
                $display("FAIL illegal vec %0d: got %b, want %b", vectors, illegal, e.ill);
            end
            if (instr_retired !== e.cnt) begin
                miscompares++;
                $display("FAIL retired vec %0d: got %0d, want %0d",
                         vectors, instr_retired, e.cnt);
            end
        end
    end

    initial begin
        reset     = 1'b0;
        opcode    = 6'd0;
        funct     = 6'd0;
        mem_ready = 1'b0;
        zero      = 1'b0;
        exp_cnt   = '0;

        // Reset held three cycles with a fetch pending: no enables may fire.
        for (int i = 0; i < 3; i++) cyc(0, LW, 6'd0, 1, 0, S_FETCH, 0, 3'b000);

        // lw straight out of reset: 0,1,2,3,4 then count 1.
        run_lw();

        // R-type sub, slt and or.
        run_rtype(F_SUB, 3'b110);
        run_rtype(F_SLT, 3'b111);
        run_rtype(F_OR,  3'b001);

        // sw: 2 wait cycles in FETCH, 3 in MEMWR -> 9 cycles total.
        fetch_dec(SW, 6'd0, 2, 0);
        cyc(1, SW, 6'd0, 1, 0, S_MEMADR, 0, 3'b000);
        for (int i = 0; i < 3; i++) cyc(1, SW, 6'd0, 0, 0, S_MEMWR, 0, 3'b000);
        cyc(1, SW, 6'd0, 1, 0, S_MEMWR, 0, 3'b000);
        retire_one();

        // beq with zero=1, then j.
        fetch_dec(BEQ, 6'd0, 0, 0);
        cyc(1, BEQ, 6'd0, 0, 1, S_BEQ_EX, 0, 3'b000);
        retire_one();
        fetch_dec(J, 6'd0, 0, 0);
        cyc(1, J, 6'd0, 0, 0, S_J_EX, 0, 3'b000);
        retire_one();

        run_addi();

        // Unsupported opcode: illegal in DECODE, back to FETCH, no count.
        fetch_dec(BAD_OP, 6'd0, 0, 1);

        // Unsupported funct: illegal in RTYPE_EX, no writeback, no count.
        fetch_dec(RT, F_BAD, 0, 0);
        cyc(1, RT, F_BAD, 0, 0, S_RT_EX, 1, 3'b000);

        // Reset during MEMRD: read suppressed, count cleared, restart in FETCH.
        fetch_dec(LW, 6'd0, 0, 0);
        cyc(1, LW, 6'd0, 0, 0, S_MEMADR, 0, 3'b000);
        cyc(0, LW, 6'd0, 1, 0, S_MEMRD,  0, 3'b000);
        exp_cnt = '0;

        // 16 addi instructions wrap the 4-bit counter back to 0.
        for (int i = 0; i < 16; i++) run_addi();

        // One more instruction, then observe the count in FETCH.
        fetch_dec(J, 6'd0, 0, 0);
        cyc(1, J, 6'd0, 0, 0, S_J_EX, 0, 3'b000);
        retire_one();
        cyc(1, RT, F_ADD, 0, 0, S_FETCH, 0, 3'b000);

        // Let the monitor drain the queue.
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors unchecked, want 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
